// File: rtl/risc16_dual_port_memory.sv
// risc16_dual_port_memory: RAM with two combinational read ports, one write port and a self-clearing reset engine.
// Define RISC16_MEM_PARITY_EN to store and check one even-parity bit per word.
module risc16_dual_port_memory #(
   parameter int WORD_LENGTH = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_SIZE    = 65536
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  iAddress,
   output logic [WORD_LENGTH-1:0] iDataOut,
   input  logic [ADDR_WIDTH-1:0]  dAddress,
   input  logic [WORD_LENGTH-1:0] dDataIn,
   input  logic                   dWriteEn,
   output logic [WORD_LENGTH-1:0] dDataOut,
   output logic                   busy,
   output logic                   addrErr,
   output logic                   iParityErr,
   output logic                   dParityErr
);
   localparam int CW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(MEM_SIZE);
   localparam logic [CW-1:0] LAST = CW'(MEM_SIZE - 1);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [WORD_LENGTH-1:0] r_mem [MEM_SIZE];
   logic                   w_i_in, w_d_in, w_i_ok, w_d_ok;
   logic [CW-1:0]          w_i_idx, w_d_idx;
   assign busy     = (r_state == CLEAR);
   assign w_i_idx  = iAddress[CW-1:0];
   assign w_d_idx  = dAddress[CW-1:0];
   assign w_i_in   = {1'b0, iAddress} < LIM;
   assign w_d_in   = {1'b0, dAddress} < LIM;
   assign w_i_ok   = w_i_in && !busy;
   assign w_d_ok   = w_d_in && !busy;
   assign addrErr  = !w_i_in || !w_d_in;
   assign iDataOut = w_i_ok ? r_mem[w_i_idx] : '0;
   assign dDataOut = w_d_ok ? r_mem[w_d_idx] : '0;
`ifdef RISC16_MEM_PARITY_EN
   logic r_par [MEM_SIZE];
   assign iParityErr = w_i_ok && (^{r_par[w_i_idx], r_mem[w_i_idx]});
   assign dParityErr = w_d_ok && (^{r_par[w_d_idx], r_mem[w_d_idx]});
`else
   assign iParityErr = 1'b0;
   assign dParityErr = 1'b0;
`endif
   // Everything updates on the falling edge; writes requested while clearing are dropped.
   always_ff @(negedge clk) begin
      if (rst) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else if (r_state == CLEAR) begin
         r_mem[r_cnt] <= '0;
`ifdef RISC16_MEM_PARITY_EN
         r_par[r_cnt] <= 1'b0;
`endif
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST) r_state <= IDLE;
      end else if (dWriteEn && w_d_in) begin
         r_mem[w_d_idx] <= dDataIn;
`ifdef RISC16_MEM_PARITY_EN
         r_par[w_d_idx] <= ^dDataIn;
`endif
      end
   end
endmodule

// File: tb/tb_risc16_dual_port_memory.sv
// tb_risc16_dual_port_memory: table-driven and directed checks of the clearing dual-port memory (MEM_SIZE=8).
module tb_risc16_dual_port_memory;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  iAddress = '0, dAddress = '0;
   logic [15:0] dDataIn = '0;
   logic        dWriteEn = 1'b0;
   logic [15:0] iDataOut, dDataOut;
   logic        busy, addrErr, iParityErr, dParityErr;
   int          checks = 0, failures = 0;
   logic [15:0] model [8];

   typedef struct {
      logic        we;
      logic [3:0]  ia;
      logic [3:0]  da;
      logic [15:0] din;
      logic [15:0] ei;
      logic [15:0] ed;
      logic        ea;
   } vec_t;
   vec_t vt [9];

   risc16_dual_port_memory #(.WORD_LENGTH(16), .ADDR_WIDTH(4), .MEM_SIZE(8)) dut (
      .clk(clk), .rst(rst), .iAddress(iAddress), .iDataOut(iDataOut),
      .dAddress(dAddress), .dDataIn(dDataIn), .dWriteEn(dWriteEn), .dDataOut(dDataOut),
      .busy(busy), .addrErr(addrErr), .iParityErr(iParityErr), .dParityErr(dParityErr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clear(output int n);
      n = 0;
      while (busy && n < 32) begin
         tick();
         n++;
      end
   endtask

   task automatic sweep(input string name);
      for (int a = 0; a < 8; a++) begin
         iAddress = 4'(a);
         dAddress = 4'(7 - a);
         #1;
         chk({name, "_i"}, iDataOut, model[a]);
         chk({name, "_d"}, dDataOut, model[7 - a]);
      end
   endtask

   task automatic zero_model();
      for (int a = 0; a < 8; a++) model[a] = '0;
   endtask

   initial begin
      int n;
      vt[0] = '{1'b1, 4'd3,  4'd3,  16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0};
      vt[1] = '{1'b1, 4'd3,  4'd5,  16'h1111, 16'hBEEF, 16'h1111, 1'b0};
      vt[2] = '{1'b0, 4'd5,  4'd3,  16'h0000, 16'h1111, 16'hBEEF, 1'b0};
      vt[3] = '{1'b1, 4'd7,  4'd7,  16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
      vt[4] = '{1'b1, 4'd0,  4'd0,  16'h0001, 16'h0001, 16'h0001, 1'b0};
      vt[5] = '{1'b1, 4'd3,  4'd9,  16'hAAAA, 16'hBEEF, 16'h0000, 1'b1};
      vt[6] = '{1'b1, 4'd8,  4'd2,  16'h00A5, 16'h0000, 16'h00A5, 1'b1};
      vt[7] = '{1'b0, 4'd15, 4'd15, 16'h0000, 16'h0000, 16'h0000, 1'b1};
      vt[8] = '{1'b0, 4'd3,  4'd2,  16'h0000, 16'hBEEF, 16'h00A5, 1'b0};

      // Power-up reset with an out-of-range instruction address.
      iAddress = 4'd9;
      tick();
      chk("rst_busy", busy, 1'b1);
      chk("rst_idata", iDataOut, 16'h0);
      chk("rst_ddata", dDataOut, 16'h0);
      chk("rst_iperr", iParityErr, 1'b0);
      chk("rst_dperr", dParityErr, 1'b0);
      chk("rst_aerr", addrErr, 1'b1);
      rst = 1'b0;
      wait_clear(n);
      chk("clear_len", n, 8);
      zero_model();
      sweep("init_zero");

      for (int k = 0; k < 9; k++) begin
         iAddress = vt[k].ia;
         dAddress = vt[k].da;
         dDataIn  = vt[k].din;
         dWriteEn = vt[k].we;
         tick();
         dWriteEn = 1'b0;
         if (vt[k].we && vt[k].da < 4'd8) model[vt[k].da] = vt[k].din;
         chk($sformatf("vec%0d_i", k), iDataOut, vt[k].ei);
         chk($sformatf("vec%0d_d", k), dDataOut, vt[k].ed);
         chk($sformatf("vec%0d_aerr", k), addrErr, vt[k].ea);
         chk($sformatf("vec%0d_perr", k), {iParityErr, dParityErr}, 2'b00);
      end
      sweep("after_table");

      // Writes during the clear are dropped, both ahead of and behind the clear pointer.
      iAddress = 4'd3;
      dAddress = 4'd3;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_busy", busy, 1'b1);
      chk("rst2_idata", iDataOut, 16'h0);
      chk("rst2_ddata", dDataOut, 16'h0);
      tick();
      tick();
      dAddress = 4'd5;
      dDataIn  = 16'h1234;
      dWriteEn = 1'b1;
      tick();
      dWriteEn = 1'b0;
      chk("clr_wr_ddata", dDataOut, 16'h0);
      tick();
      tick();
      tick();
      dAddress = 4'd0;
      dWriteEn = 1'b1;
      tick();
      dWriteEn = 1'b0;
      chk("clr7_busy", busy, 1'b1);
      tick();
      chk("clr8_busy", busy, 1'b0);
      zero_model();
      sweep("drop_wr");

      // Reset re-asserted on the 5th clear edge restarts the full clear.
      dAddress = 4'd4;
      dDataIn  = 16'h5A5A;
      dWriteEn = 1'b1;
      tick();
      dAddress = 4'd6;
      dDataIn  = 16'hC3C3;
      tick();
      dWriteEn = 1'b0;
      iAddress = 4'd4;
      #1;
      chk("pre_rst_i", iDataOut, 16'h5A5A);
      chk("pre_rst_d", dDataOut, 16'hC3C3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_clear(n);
      chk("restart_len", n, 8);
      sweep("restart_zero");

`ifdef RISC16_MEM_PARITY_EN
      iAddress = 4'd2;
      dAddress = 4'd2;
      dut.r_par[2] = ~dut.r_par[2];
      #1;
      chk("poke_dperr", dParityErr, 1'b1);
      chk("poke_iperr", iParityErr, 1'b1);
      dDataIn  = 16'h0001;
      dWriteEn = 1'b1;
      tick();
      dWriteEn = 1'b0;
      chk("fix_dperr", dParityErr, 1'b0);
      chk("fix_data", dDataOut, 16'h0001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/risc16_dual_port_memory.md
RISC16_DUAL_PORT_MEMORY -- requirements
Module: risc16_dual_port_memory

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, address width in bits for both ports.
REQ-003 SHALL have parameter MEM_SIZE, default 65536, number of words, at most 2^ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates occur on the falling edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port iAddress, input, ADDR_WIDTH, instruction-port read address.
REQ-007 SHALL have port iDataOut, output, WORD_LENGTH, instruction-port read data.
REQ-008 SHALL have port dAddress, input, ADDR_WIDTH, data-port address.
REQ-009 SHALL have port dDataIn, input, WORD_LENGTH, data-port write data.
REQ-010 SHALL have port dWriteEn, input, 1, data-port write request.
REQ-011 SHALL have port dDataOut, output, WORD_LENGTH, data-port read data.
REQ-012 SHALL have port busy, output, 1, high while the clear engine runs.
REQ-013 SHALL have port addrErr, output, 1, high when either port address is >= MEM_SIZE.
REQ-014 SHALL have ports iParityErr and dParityErr, output, 1 each, parity fault on the respective read.

Function
REQ-015 SHALL provide combinational reads on both ports: iDataOut = mem[iAddress], dDataOut = mem[dAddress].
REQ-016 SHALL write dDataIn to mem[dAddress] on a falling edge where dWriteEn=1, busy=0, rst=0 and dAddress < MEM_SIZE.
REQ-017 SHALL make a write visible on both read ports immediately after the writing edge, including when iAddress equals dAddress.
REQ-018 SHALL return 0 on a read port whose address is >= MEM_SIZE, and SHALL ignore writes to such addresses.
REQ-019 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-020 SHALL enter CLEAR with clear counter = 0 on any edge where rst=1, from either state.
REQ-021 SHALL, in CLEAR, write 0 to mem[counter] each edge, increment counter, and go to IDLE on the edge that clears word MEM_SIZE-1, taking MEM_SIZE edges in total.
REQ-022 SHALL drive busy=1 exactly while in CLEAR; busy SHALL be combinational from state.
REQ-023 SHALL force iDataOut and dDataOut to 0 while busy=1, and SHALL drop data-port writes requested while busy=1, without queuing them.
REQ-024 SHALL restart the clear at word 0 when rst is asserted during CLEAR.
REQ-025 SHALL size the counter to hold MEM_SIZE-1 without wrapping before the final compare.

Reset
REQ-026 SHALL, after the reset edge, present busy=1, iDataOut=0, dDataOut=0, iParityErr=0 and dParityErr=0, with addrErr reflecting the current addresses.
REQ-027 SHALL hold every memory word at 0, with valid parity, once busy falls.
REQ-028 SHALL treat power-up contents as undefined until the first reset completes.

Configuration
REQ-029 SHALL, with macro RISC16_MEM_PARITY_EN defined, store one even-parity bit per word, computed on write; the clear stores 0 with parity 0.
REQ-030 SHALL, with RISC16_MEM_PARITY_EN defined, drive iParityErr and dParityErr high combinationally when the addressed stored word fails parity, and low while busy=1 or the address is out of range.
REQ-031 SHALL, without RISC16_MEM_PARITY_EN, store no parity and tie iParityErr and dParityErr to 0, keeping the port list identical.

Verification (MEM_SIZE=8, ADDR_WIDTH=4, WORD_LENGTH=16)
REQ-032 SHALL cover: rst for 1 edge -> busy=1 for exactly 8 edges, then 0; every address reads 0x0000.
REQ-033 SHALL cover: write 0xBEEF at dAddress=3 with iAddress=3 -> iDataOut and dDataOut read 0xBEEF after that edge.
REQ-034 SHALL cover: dWriteEn=1 to address 5 with data 0x1234 on the 3rd clear edge -> address 5 reads 0x0000 after busy falls.
REQ-035 SHALL cover: rst re-asserted on the 5th clear edge -> busy stays high 8 further edges; all words are 0.
REQ-036 SHALL cover: dAddress=9 with write 0xAAAA -> addrErr=1, dDataOut=0, and no location is modified.
REQ-037 SHALL cover, with RISC16_MEM_PARITY_EN: force the parity bit of word 2 via hierarchical poke -> dParityErr=1 at dAddress=2, and 0 after 0x0001 is rewritten there.
